// File: rtl/status_indicator_ctrl.sv
// Multi-channel indicator driver: each channel is off, on, blinking or pulse-stretching events,
// with all timing done in ns accumulators. A global startup output-enable delay shares the same timebase.
module status_indicator_ctrl #(
    parameter int Channels_Gen              = 4,
    parameter int ClkPeriodNanosecond_Gen   = 20,
    parameter int CntWidth_Gen              = 32,
    parameter int StretchNanosecond_Gen     = 100000000,
    parameter int EnableDelayNanosecond_Gen = 1000000000
) (
    input  logic                                 SysClk_ClkIn,
    input  logic                                 SysRst_RstIn,
    input  logic [2*Channels_Gen-1:0]            Mode_DatIn,
    input  logic [CntWidth_Gen*Channels_Gen-1:0] HalfPeriod_DatIn,
    input  logic [Channels_Gen-1:0]              Invert_DatIn,
    input  logic [Channels_Gen-1:0]              Evt_EvtIn,
    output logic [Channels_Gen-1:0]              Led_DatOut,
    output logic                                 OutputEnable_EnaOut
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_STRETCH = 2'b11
    } mode_t;

    // Largest compare limit that still leaves room for one more step, so no accumulator can wrap.
    localparam logic [63:0] CntMaxWide =
        (64'd1 << CntWidth_Gen) - 64'd1 - 64'(ClkPeriodNanosecond_Gen);
    localparam logic [CntWidth_Gen-1:0] CntMax = CntMaxWide[CntWidth_Gen-1:0];
    localparam logic [CntWidth_Gen-1:0] Step   = CntWidth_Gen'(ClkPeriodNanosecond_Gen);
    localparam logic [CntWidth_Gen-1:0] StretchLim =
        (64'(StretchNanosecond_Gen) > CntMaxWide) ? CntMax : CntWidth_Gen'(StretchNanosecond_Gen);
    localparam logic [CntWidth_Gen-1:0] DelayLim =
        (64'(EnableDelayNanosecond_Gen) > CntMaxWide) ? CntMax : CntWidth_Gen'(EnableDelayNanosecond_Gen);

    logic [Channels_Gen-1:0] led_state;

    for (genvar c = 0; c < Channels_Gen; c++) begin : g_ch
        mode_t                   mode_now;
        mode_t                   mode_q;
        logic [CntWidth_Gen-1:0] half_raw;
        logic [CntWidth_Gen-1:0] half;
        logic [CntWidth_Gen-1:0] cnt_q;
        logic [CntWidth_Gen-1:0] cnt_d;
        logic                    led_q;
        logic                    led_d;
        logic                    act_q;
        logic                    act_d;
        logic                    evt_q;
        logic                    changed;
        logic                    rise;

        assign mode_now = mode_t'(Mode_DatIn[2*c +: 2]);
        assign half_raw = HalfPeriod_DatIn[CntWidth_Gen*c +: CntWidth_Gen];
        assign half     = (half_raw > CntMax) ? CntMax : half_raw;
        assign changed  = (mode_now != mode_q);
        assign rise     = Evt_EvtIn[c] & ~evt_q;

        always_comb begin
            led_d = led_q;
            cnt_d = cnt_q;
            act_d = act_q;
            if (changed) begin
                cnt_d = '0;
                act_d = 1'b0;
            end
            case (mode_now)
                MODE_OFF: led_d = 1'b0;
                MODE_ON:  led_d = 1'b1;
                MODE_BLINK: begin
                    if (changed) begin
                        led_d = 1'b0;
                    end else if (cnt_q < half) begin
                        cnt_d = cnt_q + Step;
                    end else begin
                        led_d = ~led_q;
                        cnt_d = '0;
                    end
                end
                MODE_STRETCH: begin
                    // A fresh event edge always wins, including on the mode-entry cycle.
                    if (rise) begin
                        led_d = 1'b1;
                        cnt_d = '0;
                        act_d = 1'b1;
                    end else if (changed || !act_q) begin
                        led_d = 1'b0;
                    end else if (cnt_q >= StretchLim) begin
                        led_d = 1'b0;
                        act_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + Step;
                    end
                end
                default: led_d = 1'b0;
            endcase
        end

        always_ff @(posedge SysClk_ClkIn) begin
            if (SysRst_RstIn) begin
                mode_q <= MODE_OFF;
                cnt_q  <= '0;
                led_q  <= 1'b0;
                act_q  <= 1'b0;
                evt_q  <= 1'b0;
            end else begin
                mode_q <= mode_now;
                cnt_q  <= cnt_d;
                led_q  <= led_d;
                act_q  <= act_d;
                evt_q  <= Evt_EvtIn[c];
            end
        end

        assign led_state[c] = led_q;
    end

    assign Led_DatOut = led_state ^ Invert_DatIn;

    logic [CntWidth_Gen-1:0] rst_cnt_q;
    logic [CntWidth_Gen-1:0] rst_cnt_d;
    logic                    ena_q;

    // Saturating startup timer; the enable rises on the edge the limit is first reached.
    always_comb begin
        rst_cnt_d = rst_cnt_q;
        if (rst_cnt_q < DelayLim) begin
            rst_cnt_d = rst_cnt_q + Step;
        end
    end

    always_ff @(posedge SysClk_ClkIn) begin
        if (SysRst_RstIn) begin
            rst_cnt_q <= '0;
            ena_q     <= 1'b0;
        end else begin
            rst_cnt_q <= rst_cnt_d;
            ena_q     <= (rst_cnt_d >= DelayLim);
        end
    end

    assign OutputEnable_EnaOut = ena_q;

endmodule

// File: tb/tb_status_indicator_ctrl.sv
// Bench for status_indicator_ctrl: a cycle-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed toggle intervals, pulse lengths and enable timing.
module tb_status_indicator_ctrl;

    localparam int C = 4;
    localparam int P = 20;
    localparam int W = 32;
    localparam int S = 200;
    localparam int D = 1000;

    logic           clk = 1'b0;
    logic           rst;
    logic [2*C-1:0] mode;
    logic [W*C-1:0] half;
    logic [C-1:0]   inv;
    logic [C-1:0]   evt;
    logic [C-1:0]   led;
    logic           ena;

    logic [1:0]     mode_s;
    logic [7:0]     half_s;
    logic           inv_s;
    logic           evt_s;
    logic           led_s;
    logic           ena_s;

    always #5 clk = ~clk;

    status_indicator_ctrl #(
        .Channels_Gen(C), .ClkPeriodNanosecond_Gen(P), .CntWidth_Gen(W),
        .StretchNanosecond_Gen(S), .EnableDelayNanosecond_Gen(D)
    ) dut (
        .SysClk_ClkIn(clk), .SysRst_RstIn(rst), .Mode_DatIn(mode), .HalfPeriod_DatIn(half),
        .Invert_DatIn(inv), .Evt_EvtIn(evt), .Led_DatOut(led), .OutputEnable_EnaOut(ena)
    );

    // Narrow-accumulator instance for the half-period clamp.
    status_indicator_ctrl #(
        .Channels_Gen(1), .ClkPeriodNanosecond_Gen(20), .CntWidth_Gen(8),
        .StretchNanosecond_Gen(200), .EnableDelayNanosecond_Gen(200)
    ) dut_small (
        .SysClk_ClkIn(clk), .SysRst_RstIn(rst), .Mode_DatIn(mode_s), .HalfPeriod_DatIn(half_s),
        .Invert_DatIn(inv_s), .Evt_EvtIn(evt_s), .Led_DatOut(led_s), .OutputEnable_EnaOut(ena_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Edges since the most recent reset edge.
    int cyc = 0;
    always @(posedge clk) begin
        if (rst) cyc = 0;
        else     cyc++;
    end

    // Behavioural model: k counts edges since the channel's time base last restarted,
    // so the elapsed time is simply k*P ns.
    bit         m_valid = 1'b0;
    bit         m_led  [C];
    bit         m_act  [C];
    bit         m_evtp [C];
    bit [1:0]   m_modep[C];
    int         m_k    [C];
    int         m_n;
    bit         m_ena;

    always @(posedge clk) begin : model
        bit [1:0] m;
        bit       ch;
        bit       rs;
        longint   hc;
        if (rst) begin
            m_valid = 1'b1;
            for (int c = 0; c < C; c++) begin
                m_led[c] = 0; m_act[c] = 0; m_evtp[c] = 0; m_modep[c] = 2'b00; m_k[c] = 0;
            end
            m_n   = 0;
            m_ena = 0;
        end else begin
            m_n++;
            m_ena = (longint'(m_n) * P >= D);
            for (int c = 0; c < C; c++) begin
                m  = mode[2*c +: 2];
                ch = (m != m_modep[c]);
                rs = evt[c] && !m_evtp[c];
                hc = longint'(half[W*c +: W]);
                if (hc > (longint'(1) << W) - 1 - P) hc = (longint'(1) << W) - 1 - P;
                case (m)
                    2'b00: m_led[c] = 0;
                    2'b01: m_led[c] = 1;
                    2'b10: begin
                        if (ch) begin
                            m_led[c] = 0; m_k[c] = 0;
                        end else if (longint'(m_k[c]) * P >= hc) begin
                            m_led[c] = !m_led[c]; m_k[c] = 0;
                        end else begin
                            m_k[c]++;
                        end
                    end
                    default: begin
                        if (rs) begin
                            m_led[c] = 1; m_k[c] = 0; m_act[c] = 1;
                        end else if (ch || !m_act[c]) begin
                            m_led[c] = 0; m_act[c] = 0;
                        end else if (longint'(m_k[c]) * P >= S) begin
                            m_led[c] = 0; m_act[c] = 0;
                        end else begin
                            m_k[c]++;
                        end
                    end
                endcase
                m_modep[c] = m;
                m_evtp[c]  = evt[c];
            end
        end
    end

    logic [C-1:0] exp_led;
    always @(negedge clk) begin
        if (m_valid) begin
            for (int c = 0; c < C; c++) exp_led[c] = m_led[c] ^ inv[c];
            check_eq("led_vs_model", led, exp_led);
            check_eq("ena_vs_model", ena, m_ena);
        end
    end

    // Timing monitors for the literal enable / clamp expectations.
    int ena_rise   = -1;
    int s_first    = -1;
    int s_ena_rise = -1;
    bit ena_seen, s_seen, s_ena_seen;
    always @(negedge clk) begin
        if (cyc == 0) begin
            ena_seen = 0; s_seen = 0; s_ena_seen = 0;
            ena_rise = -1; s_first = -1; s_ena_rise = -1;
        end else begin
            if (!ena_seen && ena === 1'b1)     begin ena_seen = 1;   ena_rise = cyc;   end
            if (!s_seen && led_s === 1'b1)     begin s_seen = 1;     s_first = cyc;    end
            if (!s_ena_seen && ena_s === 1'b1) begin s_ena_seen = 1; s_ena_rise = cyc; end
        end
    end

    task automatic wait_led(input int c, input logic val, input int max, output int n);
        n = 0;
        do begin
            @(posedge clk); n++; @(negedge clk);
        end while (led[c] !== val && n < max);
    endtask

    task automatic wait_small(input logic val, input int max, output int n);
        n = 0;
        do begin
            @(posedge clk); n++; @(negedge clk);
        end while (led_s !== val && n < max);
    endtask

    // Starts at a negedge: raises evt[c], holds it for 'hold' cycles, optionally re-raises it
    // at cycle re_at, and counts the cycles the (non-inverted) output is high.
    task automatic stretch_run(input int c, input int hold, input int re_at, output int n);
        n = 0;
        evt[c] = 1'b1;
        for (int i = 1; i < 120; i++) begin
            @(negedge clk);
            if (led[c] === 1'b1) n++;
            evt[c] = (i < hold) || (i == re_at);
        end
        evt[c] = 1'b0;
    endtask

    initial begin : stimulus
        int n;
        rst = 1'b1; mode = '0; half = '0; inv = 4'b0100; evt = '0;
        mode_s = 2'b00; half_s = 8'd0; inv_s = 1'b0; evt_s = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_led", led, 4'b0100);
        check_eq("reset_ena", ena, 1'b0);

        // ch3 on, ch2 off, ch1 stretch, ch0 blink H=100; small instance blink H=255
        rst = 1'b0;
        mode = {2'b01, 2'b00, 2'b11, 2'b10};
        half[31:0] = 100;
        mode_s = 2'b10; half_s = 8'd255;
        wait_led(0, 1'b1, 200, n); check_eq("blink_first_toggle", n, 7);
        wait_led(0, 1'b0, 200, n); check_eq("blink_interval", n, 6);
        half[31:0] = 0;
        wait_led(0, 1'b1, 200, n); check_eq("blink_h0_rise", n, 1);
        wait_led(0, 1'b0, 200, n); check_eq("blink_h0_fall", n, 1);

        stretch_run(1, 1, -1, n); check_eq("stretch_single", n, 11);
        stretch_run(1, 1, 5, n);  check_eq("stretch_retrigger", n, 16);
        stretch_run(1, 50, -1, n); check_eq("stretch_held", n, 11);

        check_eq("ena_rise_cycle", ena_rise, 50);

        check_eq("ch2_off_inv", led[2], 1'b1);
        mode[5:4] = 2'b01;
        @(negedge clk); check_eq("ch2_on_inv", led[2], 1'b0);
        mode[5:4] = 2'b00;
        @(negedge clk); check_eq("ch2_off2_inv", led[2], 1'b1);
        half[95:64] = 100; mode[5:4] = 2'b10;
        @(negedge clk); check_eq("ch2_blink_entry", led[2], 1'b1);
        wait_led(2, 1'b0, 200, n); check_eq("ch2_blink_first", n, 6);

        check_eq("clamp_first_toggle", s_first, 14);
        check_eq("small_ena_rise", s_ena_rise, 10);
        wait_small(!led_s, 200, n);
        wait_small(!led_s, 200, n); check_eq("clamp_interval_a", n, 13);
        wait_small(!led_s, 200, n); check_eq("clamp_interval_b", n, 13);

        // Reset in the middle of blink on ch0/ch2 and stretch on ch1/ch3.
        half[31:0] = 60; mode[7:6] = 2'b11; evt[3] = 1'b1; evt[1] = 1'b1;
        @(negedge clk); evt[1] = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check_eq("midop_reset_led", led, 4'b0100);
        check_eq("midop_reset_ena", ena, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("resume_ch0_entry", led[0], 1'b0);
        check_eq("resume_ch3_entry_rise", led[3], 1'b1);
        wait_led(0, 1'b1, 200, n); check_eq("resume_blink_first", n, 4);
        wait_led(0, 1'b0, 200, n); check_eq("resume_blink_interval", n, 4);
        n = 0;
        while (cyc < 60 && n < 200) begin
            @(negedge clk); n++;
        end
        check_eq("ena_restart_cycle", ena_rise, 50);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/status_indicator_ctrl.md
Name: status_indicator_ctrl

Overview:
Multi-channel LED and status-output driver. It replaces the fixed per-LED blink processes and the one-shot GNSS-UART output-enable delay in the top level with one parametrised block. Each channel runs in one of four runtime-selected modes: off, on, blink with a runtime half-period in ns, or event pulse-stretch (e.g. PPS made visible). A global startup output-enable delay comes out of the same block. It sits in the top level, on the board clock domain from the block design.

Parameters:
Channels_Gen, 4, number of independent indicator channels (1..16)
ClkPeriodNanosecond_Gen, 20, SysClk_ClkIn period in ns, added to counters each cycle
CntWidth_Gen, 32, width of all ns accumulators
StretchNanosecond_Gen, 100000000, pulse-stretch hold time in ns (stretch mode)
EnableDelayNanosecond_Gen, 1000000000, delay from reset release to OutputEnable_EnaOut

Ports:
SysClk_ClkIn  in  1  system clock; all logic on its rising edge
SysRst_RstIn  in  1  synchronous, active-high reset
Mode_DatIn  in  2*Channels_Gen  per channel [2c+1:2c]: 00 off, 01 on, 10 blink, 11 stretch
HalfPeriod_DatIn  in  CntWidth_Gen*Channels_Gen  per-channel blink half-period in ns
Invert_DatIn  in  Channels_Gen  per-channel output polarity invert
Evt_EvtIn  in  Channels_Gen  per-channel event input, already synchronous to SysClk_ClkIn
Led_DatOut  out  Channels_Gen  indicator outputs
OutputEnable_EnaOut  out  1  high once the startup delay has elapsed

Behaviour:
- Reset (SysRst_RstIn=1 at a clock edge): LedState, all counters, the event-edge registers and the mode-shadow registers clear to 0. OutputEnable_EnaOut=0.
- Led_DatOut[c] = LedState[c] XOR Invert_DatIn[c] (combinational). During and after reset, Led_DatOut therefore equals Invert_DatIn.
- Mode shadow: the registered copy of Mode_DatIn per channel. When the new mode differs from the shadow, the channel counter clears to 0 and the stretch-active flag clears that cycle. The new mode's behaviour starts on the same edge.
- Off: LedState=0 from the next edge.
- On: LedState=1 from the next edge.
- Blink:
  - Each cycle: if Cnt < HalfPeriod, Cnt += ClkPeriodNanosecond_Gen. Otherwise LedState toggles and Cnt=0.
  - Toggle interval is ceil(H/P)+1 cycles. H=0 toggles every cycle.
  - On entering blink from another mode: LedState=0 and Cnt=0 on the entry edge.
  - A HalfPeriod change while blinking takes effect at the next compare; there is no restart.
- Stretch:
  - Rising edge of Evt_EvtIn[c] (current=1, previous=0): LedState=1 and Cnt=0 on the next edge.
  - While active, Cnt += P each cycle until Cnt >= StretchNanosecond_Gen, then LedState=0.
  - A rising edge while active restarts Cnt=0 (retrigger extends). An edge and expiry in the same cycle: the edge wins.
  - Evt_EvtIn held high gives one pulse only.
  - Edge registers update in all modes. A rising edge on the cycle the channel enters stretch is honoured.
- Counter overflow: HalfPeriod values above 2^CntWidth_Gen-1-P are clamped internally to that value, so the accumulator never wraps.
- Output enable:
  - Global accumulator RstCnt += P while RstCnt < EnableDelayNanosecond_Gen.
  - OutputEnable_EnaOut goes high on the edge where RstCnt first reaches >= EnableDelayNanosecond_Gen.
  - It then holds (the counter saturates) until reset.
  - EnableDelayNanosecond_Gen=0 gives 1 on the first edge after reset release.
- Reset mid-operation: every channel returns to the reset state on that edge, regardless of mode or counter. Output enable drops to 0 and the delay restarts.
- Channels are fully independent; no shared arbitration.

Test Plan:
1. P=20, ch0 blink H=100, no invert. Release reset → Led_DatOut[0] toggles every 6 cycles (first toggle 6 cycles after the mode edge). Set H=0 → toggles every cycle.
2. ch1 stretch, Stretch=200 → 1-cycle Evt pulse gives Led high for 11 cycles starting 1 cycle after the edge. A second pulse 5 cycles in extends high to 16 cycles total. Evt held high 50 cycles → exactly one 11-cycle pulse.
3. ch2 cycles off → on → off → blink with Invert=1 → Led reads 1, 0, 1, then blink starts at 1 (LedState=0 inverted) and counts from 0. During reset Led[2]=1.
4. EnableDelay=1000, P=20 → OutputEnable_EnaOut=0 for 50 cycles after release, 1 from cycle 51 onward. Reset pulse at cycle 80 → 0, and the 50-cycle delay restarts.
5. Clamp: CntWidth_Gen=8, H=255 → Cnt never wraps; toggle interval is ceil(235/20)+1 = 13 cycles.
6. Reset asserted mid-blink and mid-stretch on all 4 channels → all LedState=0 and counters 0 on that edge. Modes resume cleanly after release, with blink first toggle exactly ceil(H/P)+1 cycles later.
